// File: rtl/mem_io_responder_if.sv
// MEM-stage data bus between the pipelined MIPS core (master) and the data-memory responder (slave).
interface mem_io_responder_if;
    logic [31:0] Address;
    logic [31:0] WriteData;
    logic        MemWrite;
    logic        MemRead;
    logic [31:0] ReadData;

    modport master (output Address, output WriteData, output MemWrite, output MemRead,
                    input  ReadData);
    modport slave  (input  Address, input  WriteData, input  MemWrite, input  MemRead,
                    output ReadData);
endinterface

// File: rtl/mem_io_responder.sv
// Data-memory responder: word RAM plus memory-mapped port, control/status and timer registers.
// Loads return combinationally in the MEM cycle; stores commit on the rising clock edge.
module mem_io_responder #(
    parameter int unsigned RAM_DEPTH = 64,
    parameter logic [31:0] RAM_BASE  = 32'h1001_0000,
    parameter logic [31:0] IO_BASE   = 32'hFFFF_0000
) (
    input  logic                      clk,
    input  logic                      reset,
    mem_io_responder_if.slave         bus,
    input  logic [7:0]                PortIn,
    output logic [31:0]               PortOut,
    output logic                      Irq
);

    localparam int          RAM_AW    = (RAM_DEPTH > 1) ? $clog2(RAM_DEPTH) : 1;
    localparam logic [31:0] RAM_BYTES = 32'(RAM_DEPTH) << 2;

    typedef enum logic [4:0] {
        IO_PORT_IN  = 5'h00,
        IO_PORT_OUT = 5'h04,
        IO_CTRL     = 5'h08,
        IO_TIMER    = 5'h0C,
        IO_TCMP     = 5'h10
    } io_reg_e;

    // Address decode
    logic [31:0]       ram_off, io_off;
    logic [RAM_AW-1:0] ram_idx;
    logic              ram_hit, io_hit, access_err;
    logic              wr_ok, rd_ok;
    io_reg_e           io_reg;

    assign ram_off = bus.Address - RAM_BASE;
    assign io_off  = bus.Address - IO_BASE;
    assign ram_idx = ram_off[RAM_AW+1:2];
    assign ram_hit = ram_off < RAM_BYTES;
    assign io_hit  = io_off <= 32'h10;
    assign io_reg  = io_reg_e'(io_off[4:0]);

    assign access_err = (bus.MemRead | bus.MemWrite) &
                        ((bus.Address[1:0] != 2'b00) |
                         ~(ram_hit | io_hit) |
                         (bus.MemRead & bus.MemWrite) |
                         (bus.MemWrite & ~ram_hit & io_hit & (io_reg == IO_PORT_IN)));

    assign wr_ok = bus.MemWrite & ~access_err;
    assign rd_ok = bus.MemRead & ~bus.MemWrite & ~access_err;

    logic wr_ram, wr_io, wr_port_out, wr_ctrl, wr_timer, wr_tcmp;

    assign wr_ram      = wr_ok & ram_hit;
    assign wr_io       = wr_ok & ~ram_hit & io_hit;
    assign wr_port_out = wr_io & (io_reg == IO_PORT_OUT);
    assign wr_ctrl     = wr_io & (io_reg == IO_CTRL);
    assign wr_timer    = wr_io & (io_reg == IO_TIMER);
    assign wr_tcmp     = wr_io & (io_reg == IO_TCMP);

    // RAM
    logic [31:0] ram_q [RAM_DEPTH];

    // NOTE: the RAM array has no reset branch; clearing it would turn the storage into flops.
    always_ff @(posedge clk) begin
        if (wr_ram) ram_q[ram_idx] <= bus.WriteData;
    end

    // Register state
    logic [31:0] port_out_q, port_out_d;
    logic [31:0] timer_q, timer_d;
    logic [31:0] tcmp_q, tcmp_d;
    logic        timer_en_q, timer_en_d;
    logic        irq_en_q, irq_en_d;
    logic        in_changed_q, in_changed_d;
    logic        timer_hit_q, timer_hit_d;
    logic        bus_err_q, bus_err_d;
    logic [7:0]  sync1_q, sync2_q, sync_prev_q;
    logic        irq_q, irq_d;

    logic timer_match;
    assign timer_match = timer_en_q & (timer_q == tcmp_q);

    // NOTE: every _d gets its hold value first so no path through this block infers a latch.
    always_comb begin
        port_out_d   = port_out_q;
        tcmp_d       = tcmp_q;
        timer_en_d   = timer_en_q;
        irq_en_d     = irq_en_q;
        timer_d      = timer_q;

        if (wr_port_out) port_out_d = bus.WriteData;
        if (wr_tcmp)     tcmp_d     = bus.WriteData;
        if (wr_ctrl) begin
            timer_en_d = bus.WriteData[0];
            irq_en_d   = bus.WriteData[1];
        end

        // A software load of TIMER beats both the compare reload and the increment.
        if (wr_timer)         timer_d = bus.WriteData;
        else if (timer_match) timer_d = 32'd0;
        else if (timer_en_q)  timer_d = timer_q + 32'd1;

        // Sticky flags: a hardware set in the same cycle as write-1-to-clear keeps the flag.
        in_changed_d = (sync2_q != sync_prev_q) |
                       (in_changed_q & ~(wr_ctrl & bus.WriteData[8]));
        timer_hit_d  = (timer_match & ~wr_timer) |
                       (timer_hit_q & ~(wr_ctrl & bus.WriteData[9]));
        bus_err_d    = access_err |
                       (bus_err_q & ~(wr_ctrl & bus.WriteData[10]));

        irq_d = irq_en_q & (in_changed_q | timer_hit_q);
    end

    // NOTE: state updates use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            port_out_q   <= '0;
            timer_q      <= '0;
            tcmp_q       <= 32'hFFFF_FFFF;
            timer_en_q   <= 1'b0;
            irq_en_q     <= 1'b0;
            in_changed_q <= 1'b0;
            timer_hit_q  <= 1'b0;
            bus_err_q    <= 1'b0;
            sync1_q      <= '0;
            sync2_q      <= '0;
            sync_prev_q  <= '0;
            irq_q        <= 1'b0;
        end else begin
            port_out_q   <= port_out_d;
            timer_q      <= timer_d;
            tcmp_q       <= tcmp_d;
            timer_en_q   <= timer_en_d;
            irq_en_q     <= irq_en_d;
            in_changed_q <= in_changed_d;
            timer_hit_q  <= timer_hit_d;
            bus_err_q    <= bus_err_d;
            sync1_q      <= PortIn;
            sync2_q      <= sync1_q;
            sync_prev_q  <= sync2_q;
            irq_q        <= irq_d;
        end
    end

    // Load data path
    logic [31:0] read_data;

    always_comb begin
        read_data = '0;
        if (rd_ok) begin
            if (ram_hit) begin
                read_data = ram_q[ram_idx];
            end else begin
                case (io_reg)
                    IO_PORT_IN:  read_data = {24'd0, sync2_q};
                    IO_PORT_OUT: read_data = port_out_q;
                    IO_CTRL:     read_data = {21'd0, bus_err_q, timer_hit_q, in_changed_q,
                                              6'd0, irq_en_q, timer_en_q};
                    IO_TIMER:    read_data = timer_q;
                    IO_TCMP:     read_data = tcmp_q;
                    default:     read_data = '0;
                endcase
            end
        end
    end

    assign bus.ReadData = read_data;
    assign PortOut      = port_out_q;
    assign Irq          = irq_q;

endmodule

// File: tb/tb_mem_io_responder.sv
// Directed bench for mem_io_responder: RAM, I/O registers, synchronizer, timer, errors, reset.
module tb_mem_io_responder;

    localparam logic [31:0] RAM_BASE = 32'h1001_0000;
    localparam logic [31:0] IO_BASE  = 32'hFFFF_0000;
    localparam logic [31:0] A_PIN    = IO_BASE + 32'h00;
    localparam logic [31:0] A_POUT   = IO_BASE + 32'h04;
    localparam logic [31:0] A_CTRL   = IO_BASE + 32'h08;
    localparam logic [31:0] A_TIMER  = IO_BASE + 32'h0C;
    localparam logic [31:0] A_TCMP   = IO_BASE + 32'h10;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  PortIn;
    logic [31:0] PortOut;
    logic        Irq;

    int compared   = 0;
    int mismatched = 0;

    mem_io_responder_if bus ();

    mem_io_responder #(
        .RAM_DEPTH (64),
        .RAM_BASE  (RAM_BASE),
        .IO_BASE   (IO_BASE)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .bus     (bus),
        .PortIn  (PortIn),
        .PortOut (PortOut),
        .Irq     (Irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $error("FAIL %s: observed %08h expected %08h", tag, observed, expected);
        end
    endtask

    task automatic bus_idle();
        bus.MemRead   = 1'b0;
        bus.MemWrite  = 1'b0;
        bus.WriteData = '0;
    endtask

    // Combinational load with no clock edge while the strobe is up.
    task automatic peek(input logic [31:0] addr, output logic [31:0] data);
        bus.Address  = addr;
        bus.MemRead  = 1'b1;
        bus.MemWrite = 1'b0;
        #1 data = bus.ReadData;
        bus_idle();
    endtask

    task automatic expect_rd(input string tag, input logic [31:0] addr, input logic [31:0] exp);
        logic [31:0] d;
        peek(addr, d);
        check(tag, d, exp);
    endtask

    // One bus cycle spanning exactly one rising edge; returns ReadData seen before the edge.
    task automatic acc(input logic [31:0] addr, input logic rd, input logic wr,
                       input logic [31:0] wdata, output logic [31:0] rdata);
        bus.Address   = addr;
        bus.WriteData = wdata;
        bus.MemRead   = rd;
        bus.MemWrite  = wr;
        #1 rdata = bus.ReadData;
        @(posedge clk);
        #1 bus_idle();
    endtask

    task automatic wr(input logic [31:0] addr, input logic [31:0] data);
        logic [31:0] unused_rd;
        acc(addr, 1'b0, 1'b1, data, unused_rd);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] rd;
        reset       = 1'b0;
        PortIn      = 8'h00;
        bus.Address = '0;
        bus_idle();
        tick(2);
        reset = 1'b1;
        tick(1);

        // Reset state
        expect_rd("rst_portout_reg", A_POUT, 32'h0);
        expect_rd("rst_tcmp", A_TCMP, 32'hFFFF_FFFF);
        expect_rd("rst_ctrl", A_CTRL, 32'h0);
        expect_rd("rst_timer", A_TIMER, 32'h0);
        check("rst_irq", {31'd0, Irq}, 32'h0);
        check("rst_portout_pin", PortOut, 32'h0);

        // RAM write/read, top word, out-of-range read
        wr(RAM_BASE + 32'h8, 32'hDEAD_BEEF);
        expect_rd("ram_word2", RAM_BASE + 32'h8, 32'hDEAD_BEEF);
        wr(RAM_BASE + 32'hFC, 32'h0BAD_F00D);
        expect_rd("ram_last_word", RAM_BASE + 32'hFC, 32'h0BAD_F00D);
        acc(RAM_BASE + 32'h100, 1'b1, 1'b0, 32'h0, rd);
        check("ram_oob_rdata", rd, 32'h0);
        expect_rd("ram_oob_buserr", A_CTRL, 32'h0000_0400);
        wr(A_CTRL, 32'h0000_0400);
        expect_rd("buserr_w1c", A_CTRL, 32'h0);

        // Input synchronizer, in_changed and Irq
        wr(A_CTRL, 32'h0000_0002);
        PortIn = 8'hA5;
        expect_rd("pin_edge0", A_PIN, 32'h0);
        tick(1);
        expect_rd("pin_edge1", A_PIN, 32'h0);
        tick(1);
        expect_rd("pin_edge2", A_PIN, 32'h0000_00A5);
        expect_rd("inchg_not_yet", A_CTRL, 32'h0000_0002);
        tick(1);
        expect_rd("inchg_set", A_CTRL, 32'h0000_0102);
        check("irq_lag", {31'd0, Irq}, 32'h0);
        tick(1);
        check("irq_inchg", {31'd0, Irq}, 32'h1);
        wr(A_CTRL, 32'h0000_0102);
        expect_rd("inchg_w1c", A_CTRL, 32'h0000_0002);
        check("irq_still_high", {31'd0, Irq}, 32'h1);
        tick(1);
        check("irq_cleared", {31'd0, Irq}, 32'h0);

        // Output port
        wr(A_POUT, 32'h1234_5678);
        check("portout_pin", PortOut, 32'h1234_5678);
        expect_rd("portout_reg", A_POUT, 32'h1234_5678);

        // Timer count and compare
        wr(A_TCMP, 32'd3);
        wr(A_CTRL, 32'h0000_0003);
        expect_rd("timer_0", A_TIMER, 32'd0);
        tick(1);
        expect_rd("timer_1", A_TIMER, 32'd1);
        tick(1);
        expect_rd("timer_2", A_TIMER, 32'd2);
        tick(1);
        expect_rd("timer_3", A_TIMER, 32'd3);
        tick(1);
        expect_rd("timer_reload", A_TIMER, 32'd0);
        expect_rd("timer_hit_set", A_CTRL, 32'h0000_0203);
        check("irq_hit_lag", {31'd0, Irq}, 32'h0);
        tick(1);
        check("irq_hit", {31'd0, Irq}, 32'h1);
        expect_rd("timer_after_reload", A_TIMER, 32'd1);

        // Software load on a match cycle wins; no hit that cycle
        wr(A_CTRL, 32'h0000_0203);
        expect_rd("hit_w1c", A_CTRL, 32'h0000_0003);
        tick(1);
        check("irq_hit_cleared", {31'd0, Irq}, 32'h0);
        expect_rd("timer_at_match", A_TIMER, 32'd3);
        wr(A_TIMER, 32'd3);
        expect_rd("timer_write_wins", A_TIMER, 32'd3);
        expect_rd("no_hit_on_write", A_CTRL, 32'h0000_0003);
        tick(1);
        expect_rd("hit_after_write", A_CTRL, 32'h0000_0203);

        // Set wins over W1C in the same cycle
        tick(3);
        expect_rd("timer_at_match2", A_TIMER, 32'd3);
        wr(A_CTRL, 32'h0000_0203);
        expect_rd("hit_set_wins", A_CTRL, 32'h0000_0203);
        expect_rd("timer_reload2", A_TIMER, 32'd0);

        // 32-bit wrap with no compare match
        wr(A_CTRL, 32'h0000_0203);
        expect_rd("hit_w1c2", A_CTRL, 32'h0000_0003);
        wr(A_TIMER, 32'hFFFF_FFFE);
        tick(1);
        expect_rd("timer_max", A_TIMER, 32'hFFFF_FFFF);
        tick(1);
        expect_rd("timer_wrap", A_TIMER, 32'h0);
        expect_rd("wrap_no_hit", A_CTRL, 32'h0000_0003);
        wr(A_CTRL, 32'h0);

        // Access errors
        wr(RAM_BASE, 32'h1111_1111);
        acc(RAM_BASE + 32'h2, 1'b0, 1'b1, 32'h2222_2222, rd);
        expect_rd("misaligned_ram_kept", RAM_BASE, 32'h1111_1111);
        expect_rd("misaligned_buserr", A_CTRL, 32'h0000_0400);
        wr(A_CTRL, 32'h0000_0400);
        acc(A_POUT, 1'b1, 1'b1, 32'hCAFE_F00D, rd);
        check("rdwr_rdata", rd, 32'h0);
        check("rdwr_portout_kept", PortOut, 32'h1234_5678);
        expect_rd("rdwr_buserr", A_CTRL, 32'h0000_0400);
        wr(A_CTRL, 32'h0000_0400);
        acc(A_PIN, 1'b0, 1'b1, 32'h0000_005A, rd);
        expect_rd("pin_write_buserr", A_CTRL, 32'h0000_0400);
        expect_rd("pin_unchanged", A_PIN, 32'h0000_00A5);
        wr(A_CTRL, 32'h0000_0400);
        acc(IO_BASE + 32'h14, 1'b1, 1'b0, 32'h0, rd);
        check("unmapped_rdata", rd, 32'h0);
        expect_rd("unmapped_buserr", A_CTRL, 32'h0000_0400);

        // No load strobe: ReadData is zero
        bus.Address = A_POUT;
        #1 check("idle_rdata", bus.ReadData, 32'h0);

        // Asynchronous reset between edges
        #2 reset = 1'b0;
        #1 check("async_rst_portout", PortOut, 32'h0);
        expect_rd("async_rst_tcmp", A_TCMP, 32'hFFFF_FFFF);
        expect_rd("async_rst_ctrl", A_CTRL, 32'h0);
        reset = 1'b1;
        tick(1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
